// File: rtl/spi_reg_arb.sv
// spi_reg_arb: two-port (SPI-side and local-side) arbiter in front of a
// single register bank. One access is in flight at a time. Ties between the
// ports are broken round-robin.
//
// Handshake (both request ports): the requester raises x_req with
// x_wren/x_addr/x_wdata/x_byte_en stable. It holds x_req until x_ack, a
// one-cycle pulse. x_rdata and x_err are valid with x_ack. The requester
// drops x_req the cycle after x_ack. Requests are only looked at in IDLE,
// and the command is latched at grant, so later input changes are ignored.
//
// Ports:
//   sys_clk, rst_n           clock, asynchronous active-low reset
//   spi_*                    SPI-side request/response port
//   loc_*                    local-side request/response port
//   reg_we/reg_re            bank write/read strobes (never both high)
//   reg_addr/wdata/be        latched command towards the bank
//   reg_rdata                bank read data, valid one cycle after reg_re
//   busy                     FSM not in IDLE
//   fsm_state                current FSM state (debug visibility)
module spi_reg_arb #(
  parameter int REG_NUM   = 24,
  parameter bit SPI_FIRST = 1'b1
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        spi_req,
  input  logic        spi_wren,
  input  logic [4:0]  spi_addr,
  input  logic [31:0] spi_wdata,
  input  logic [3:0]  spi_byte_en,
  output logic        spi_ack,
  output logic [31:0] spi_rdata,
  output logic        spi_err,
  input  logic        loc_req,
  input  logic        loc_wren,
  input  logic [4:0]  loc_addr,
  input  logic [31:0] loc_wdata,
  input  logic [3:0]  loc_byte_en,
  output logic        loc_ack,
  output logic [31:0] loc_rdata,
  output logic        loc_err,
  output logic        reg_we,
  output logic        reg_re,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [5:0] REG_LIM = 6'(REG_NUM);

  state_t      state_q, state_d;
  logic        grant_q;     // port owning the current access: 0 = SPI, 1 = local
  logic        last_q;      // port granted most recently: 0 = SPI, 1 = local
  logic        lat_wren;
  logic [4:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        err_q;
  logic [31:0] spi_rdata_q;
  logic [31:0] loc_rdata_q;

  logic any_req;
  logic pick_loc;
  logic in_range;

  assign any_req  = spi_req | loc_req;
  // Local wins when it is alone, or on a tie when SPI was granted last.
  assign pick_loc = loc_req & (~spi_req | ~last_q);
  assign in_range = ({1'b0, lat_addr} < REG_LIM);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = (in_range && !lat_wren) ? RD_WAIT : RESP;
      RD_WAIT: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= 1'b0;
      last_q      <= SPI_FIRST;  // pointing at local lets SPI win the first tie
      lat_wren    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      err_q       <= 1'b0;
      spi_rdata_q <= '0;
      loc_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q   <= pick_loc;
            last_q    <= pick_loc;
            lat_wren  <= pick_loc ? loc_wren    : spi_wren;
            lat_addr  <= pick_loc ? loc_addr    : spi_addr;
            lat_wdata <= pick_loc ? loc_wdata   : spi_wdata;
            lat_be    <= pick_loc ? loc_byte_en : spi_byte_en;
          end
        end
        ACCESS: begin
          err_q <= ~in_range;
          // An out-of-range read returns zero on the owning port.
          if (!in_range && !lat_wren) begin
            if (grant_q) loc_rdata_q <= '0;
            else         spi_rdata_q <= '0;
          end
        end
        RD_WAIT: begin
          if (grant_q) loc_rdata_q <= reg_rdata;
          else         spi_rdata_q <= reg_rdata;
        end
        default: ;
      endcase
    end
  end

  // Strobes and acks decode the state directly, so an asynchronous reset
  // removes them at once.
  always_comb begin
    reg_we  = 1'b0;
    reg_re  = 1'b0;
    spi_ack = 1'b0;
    loc_ack = 1'b0;
    if (state_q == ACCESS && in_range) begin
      reg_we = lat_wren & (|lat_be);
      reg_re = ~lat_wren;
    end
    if (state_q == RESP) begin
      spi_ack = ~grant_q;
      loc_ack = grant_q;
    end
  end

  assign spi_err   = spi_ack & err_q;
  assign loc_err   = loc_ack & err_q;
  assign spi_rdata = spi_rdata_q;
  assign loc_rdata = loc_rdata_q;
  assign reg_addr  = lat_addr;
  assign reg_wdata = lat_wdata;
  assign reg_be    = lat_be;
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_reg_arb.sv
// Directed testbench for spi_reg_arb. Inputs change and outputs are checked
// 1 time unit after each rising edge. A small register-bank model answers
// reads one cycle after reg_re.
module tb_spi_reg_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_req, spi_wren, loc_req, loc_wren;
  logic [4:0]  spi_addr, loc_addr;
  logic [31:0] spi_wdata, loc_wdata;
  logic [3:0]  spi_byte_en, loc_byte_en;
  logic        spi_ack, spi_err, loc_ack, loc_err;
  logic [31:0] spi_rdata, loc_rdata;
  logic        reg_we, reg_re, busy;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_be;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  spi_reg_arb #(.REG_NUM(24), .SPI_FIRST(1'b1)) dut (
    .sys_clk(clk), .rst_n(rst_n),
    .spi_req(spi_req), .spi_wren(spi_wren), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_byte_en(spi_byte_en),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata), .spi_err(spi_err),
    .loc_req(loc_req), .loc_wren(loc_wren), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_byte_en(loc_byte_en),
    .loc_ack(loc_ack), .loc_rdata(loc_rdata), .loc_err(loc_err),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // register bank model: byte-enabled writes, registered reads
  logic [31:0] mem [32];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) mem[7] <= 32'h0000_BEEF;
    if (reg_we)
      for (int b = 0; b < 4; b++)
        if (reg_be[b]) mem[reg_addr][b*8 +: 8] <= reg_wdata[b*8 +: 8];
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_spi(input logic req, input logic wren, input logic [4:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    spi_req = req; spi_wren = wren; spi_addr = addr; spi_wdata = data; spi_byte_en = be;
  endtask

  task automatic set_loc(input logic req, input logic wren, input logic [4:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    loc_req = req; loc_wren = wren; loc_addr = addr; loc_wdata = data; loc_byte_en = be;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, spi_ack, loc_ack}, 32'd0);
    chk("rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    chk("rst_spi_rdata", spi_rdata, 32'd0);
    chk("rst_loc_rdata", loc_rdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    set_spi(0, 0, 0, 0, 0);
    set_loc(0, 0, 0, 0, 0);
    reg_rdata = '0;
    tick();
    preload = 1'b0;
    do_reset();

    // SPI write addr 3
    set_spi(1, 1, 5'd3, 32'hA5A5_1234, 4'hF);
    tick();  // grant edge -> ACCESS
    chk("wr_we", {31'd0, reg_we}, 32'd1);
    chk("wr_re", {31'd0, reg_re}, 32'd0);
    chk("wr_addr", {27'd0, reg_addr}, 32'd3);
    chk("wr_wdata", reg_wdata, 32'hA5A5_1234);
    chk("wr_be", {28'd0, reg_be}, 32'hF);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    spi_wdata = 32'hDEAD_DEAD;  // must not reach the bank
    spi_addr  = 5'd9;
    tick();  // RESP
    chk("wr_we_once", {31'd0, reg_we}, 32'd0);
    chk("wr_ack", {31'd0, spi_ack}, 32'd1);
    chk("wr_err", {31'd0, spi_err}, 32'd0);
    chk("wr_loc_ack", {31'd0, loc_ack}, 32'd0);
    chk("wr_hold_wdata", reg_wdata, 32'hA5A5_1234);
    set_spi(0, 0, 0, 0, 0);
    tick();
    chk("wr_idle_ack", {31'd0, spi_ack}, 32'd0);
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);

    // local read addr 7
    set_loc(1, 0, 5'd7, 0, 0);
    tick();  // ACCESS
    chk("rd_re", {31'd0, reg_re}, 32'd1);
    chk("rd_we", {31'd0, reg_we}, 32'd0);
    tick();  // RD_WAIT
    chk("rd_re_once", {31'd0, reg_re}, 32'd0);
    chk("rd_early_ack", {31'd0, loc_ack}, 32'd0);
    tick();  // RESP
    chk("rd_ack", {31'd0, loc_ack}, 32'd1);
    chk("rd_data", loc_rdata, 32'h0000_BEEF);
    chk("rd_err", {31'd0, loc_err}, 32'd0);
    set_loc(0, 0, 0, 0, 0);
    tick();
    chk("rd_hold", loc_rdata, 32'h0000_BEEF);
    chk("rd_ack_pulse", {31'd0, loc_ack}, 32'd0);

    // tie after reset: SPI first, then local, next tie SPI
    do_reset();
    set_spi(1, 1, 5'd1, 32'h11, 4'hF);
    set_loc(1, 1, 5'd2, 32'h22, 4'hF);
    tick();
    chk("tie1_addr", {27'd0, reg_addr}, 32'd1);
    tick();
    chk("tie1_spi_ack", {31'd0, spi_ack}, 32'd1);
    chk("tie1_loc_ack", {31'd0, loc_ack}, 32'd0);
    set_spi(0, 0, 0, 0, 0);
    tick();  // IDLE, local still pending
    chk("tie_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("tie2_addr", {27'd0, reg_addr}, 32'd2);
    chk("tie2_wdata", reg_wdata, 32'h22);
    tick();
    chk("tie2_loc_ack", {31'd0, loc_ack}, 32'd1);
    chk("tie2_spi_ack", {31'd0, spi_ack}, 32'd0);
    set_loc(0, 0, 0, 0, 0);
    tick();
    set_spi(1, 1, 5'd1, 32'h33, 4'hF);
    set_loc(1, 1, 5'd2, 32'h44, 4'hF);
    tick();
    chk("tie3_addr", {27'd0, reg_addr}, 32'd1);
    tick();
    chk("tie3_spi_ack", {31'd0, spi_ack}, 32'd1);
    set_spi(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("tie4_loc_ack", {31'd0, loc_ack}, 32'd1);
    set_loc(0, 0, 0, 0, 0);
    tick();

    // SPI read addr 3, then out-of-range read addr 30
    set_spi(1, 0, 5'd3, 0, 0);
    tick(); tick(); tick();
    chk("rd3_ack", {31'd0, spi_ack}, 32'd1);
    chk("rd3_data", spi_rdata, 32'hA5A5_1234);
    set_spi(0, 0, 0, 0, 0);
    tick();
    set_spi(1, 0, 5'd30, 0, 0);
    tick();
    chk("oor_no_re", {30'd0, reg_re, reg_we}, 32'd0);
    tick();
    chk("oor_ack", {31'd0, spi_ack}, 32'd1);
    chk("oor_err", {31'd0, spi_err}, 32'd1);
    chk("oor_rdata", spi_rdata, 32'd0);
    set_spi(0, 0, 0, 0, 0);
    tick();
    chk("oor_err_clr", {31'd0, spi_err}, 32'd0);

    // reset during RD_WAIT
    set_loc(1, 0, 5'd7, 0, 0);
    tick(); tick(); tick();
    chk("pre_rst_rdata", loc_rdata, 32'h0000_BEEF);
    set_loc(0, 0, 0, 0, 0);
    tick();
    set_loc(1, 0, 5'd7, 0, 0);
    tick(); tick();  // RD_WAIT
    chk("pre_rst_state", {30'd0, fsm_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_loc_rdata", loc_rdata, 32'd0);
    chk("mid_rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    set_loc(0, 0, 0, 0, 0);
    tick();
    chk("mid_rst_no_ack", {30'd0, spi_ack, loc_ack}, 32'd0);
    rst_n = 1'b1;
    tick();
    set_spi(1, 1, 5'd5, 32'hCAFE_F00D, 4'h3);
    tick();
    chk("fresh_we", {31'd0, reg_we}, 32'd1);
    chk("fresh_be", {28'd0, reg_be}, 32'h3);
    tick();
    chk("fresh_ack", {31'd0, spi_ack}, 32'd1);
    set_spi(0, 0, 0, 0, 0);
    tick();

    // local write be=0 while SPI requests (SPI was last, so local wins)
    set_loc(1, 1, 5'd4, 32'h5555_5555, 4'h0);
    set_spi(1, 0, 5'd3, 0, 0);
    tick();
    chk("be0_addr", {27'd0, reg_addr}, 32'd4);
    chk("be0_no_we", {30'd0, reg_we, reg_re}, 32'd0);
    tick();
    chk("be0_ack", {31'd0, loc_ack}, 32'd1);
    chk("be0_err", {31'd0, loc_err}, 32'd0);
    chk("be0_spi_wait", {31'd0, spi_ack}, 32'd0);
    set_loc(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("be0_spi_re", {31'd0, reg_re}, 32'd1);
    tick(); tick();
    chk("be0_spi_ack", {31'd0, spi_ack}, 32'd1);
    chk("be0_spi_data", spi_rdata, 32'hA5A5_1234);
    set_spi(0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time limit
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
